aq_fdsu_frac_div_iter: RTL

- Iterative restoring fraction divider in the FDSU datapath.
- Its dividend input is the pre-aligned 16-bit fraction produced by the FDSU fraction right-shift stage; its divisor is the normalized divisor fraction.
- Produces one quotient bit per cycle plus a sticky (inexact) flag, and hands the result to the FDSU rounding stage with a one-cycle done pulse.

---
 rtl/aq_fdsu_frac_div_iter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/aq_fdsu_frac_div_iter.sv
// Iterative restoring fraction divider for the FDSU datapath.
// Produces one quotient bit per cycle, then a sticky flag and a one-cycle done pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for div_start
//   ITER  | one restoring step per cycle, FRAC_W cycles in total
//   DONE  | one-cycle result pulse; a new start may be accepted here
module aq_fdsu_frac_div_iter #(
   parameter int FRAC_W = 16
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst_b,
   input  logic              div_start,
   input  logic              div_kill,
   input  logic [FRAC_W-1:0] div_frac_dividend,
   input  logic [FRAC_W-1:0] div_frac_divisor,
   output logic              div_busy,
   output logic              div_done,
   output logic [FRAC_W-1:0] div_quotient,
   output logic              div_sticky,
   output logic              div_err
);

   localparam int CNT_W = $clog2(FRAC_W) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [FRAC_W:0]   rem;
   logic [FRAC_W-1:0] divisor_q;
   logic [FRAC_W-1:0] quo_work;
   logic [CNT_W-1:0]  cnt;

   logic              start_acc;
   logic              pre_ok;
   logic              last_bit;
   logic              q_bit;
   logic [FRAC_W:0]   rem_shl;
   logic [FRAC_W:0]   rem_sub;
   logic [FRAC_W:0]   rem_nxt;

   // Start is accepted outside ITER; kill always wins.
   always_comb begin
      start_acc = div_start & ~div_kill & (state != ITER);
      pre_ok    = div_frac_divisor[FRAC_W-1] & (div_frac_dividend < div_frac_divisor);
      last_bit  = (cnt == CNT_W'(1));
   end

   // Restoring step: rem stays below the divisor, so the shift never loses a bit.
   always_comb begin
      rem_shl = rem << 1;
      rem_sub = rem_shl - {1'b0, divisor_q};
      q_bit   = (rem_shl >= {1'b0, divisor_q});
      rem_nxt = q_bit ? rem_sub : rem_shl;
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      case (state)
         IDLE: begin
            if (start_acc) begin
               state_nxt = pre_ok ? ITER : DONE;
            end
         end
         ITER: begin
            div_busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            div_done = 1'b1;
            if (start_acc) begin
               state_nxt = pre_ok ? ITER : DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (div_kill) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rem          <= '0;
         divisor_q    <= '0;
         quo_work     <= '0;
         cnt          <= '0;
         div_quotient <= '0;
         div_sticky   <= 1'b0;
         div_err      <= 1'b0;
      end else if (div_kill) begin
         // Abort: working registers are don't-care in IDLE, results are kept.
         cnt <= '0;
      end else if (start_acc) begin
         divisor_q <= div_frac_divisor;
         rem       <= {1'b0, div_frac_dividend};
         cnt       <= CNT_W'(FRAC_W);
         quo_work  <= '0;
         if (!pre_ok) begin
            div_quotient <= '1;
            div_sticky   <= 1'b1;
            div_err      <= 1'b1;
         end
      end else if (state == ITER) begin
         rem      <= rem_nxt;
         quo_work <= {quo_work[FRAC_W-2:0], q_bit};
         cnt      <= cnt - CNT_W'(1);
         if (last_bit) begin
            div_quotient <= {quo_work[FRAC_W-2:0], q_bit};
            div_sticky   <= (rem_nxt != '0);
            div_err      <= 1'b0;
         end
      end
   end

endmodule
